tawas_ls_wait: RTL and testbench

Parametrised load/store unit for the Tawas core that supports wait-stated data buses. It replaces the fixed-latency no-wait access with a DREQ/DACK request handshake and in-order read responses (DRD_VLD). An issue-side ready (LS_OP_RDY) back-pressures the pipeline. Outstanding loads are tracked in a PEND_DEPTH-deep FIFO. Optional sign-extension of byte and half loads is added.

---
 rtl/tawas_ls_wait_if.sv | 22 ++
 rtl/tawas_ls_wait.sv | 222 ++++++++++++++++++++++
 tb/tb_tawas_ls_wait.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tawas_ls_wait_if.sv
// Data-bus bundle between the Tawas load/store unit and a wait-stated memory.
// The LSU is the master; the memory side is the slave.
interface tawas_ls_wait_if;
   logic        DREQ;
   logic        DACK;
   logic [31:0] DADDR;
   logic        DWR;
   logic [3:0]  DMASK;
   logic [31:0] DOUT;
   logic        DRD_VLD;
   logic [31:0] DIN;

   modport master (
      output DREQ, DADDR, DWR, DMASK, DOUT,
      input  DACK, DRD_VLD, DIN
   );

   modport slave (
      input  DREQ, DADDR, DWR, DMASK, DOUT,
      output DACK, DRD_VLD, DIN
   );
endinterface

// File: rtl/tawas_ls_wait.sv
// Tawas load/store unit for wait-stated data buses: DREQ/DACK request handshake,
// in-order read responses tracked in a PEND_DEPTH-deep pending-load FIFO.
module tawas_ls_wait #(
   parameter int PEND_DEPTH  = 4,
   parameter int PEND_AW     = 2,
   parameter bit SIGN_EXT_EN = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,

   input  logic        LS_OP_VLD,
   output logic        LS_OP_RDY,
   input  logic [15:0] LS_OP,
   output logic [2:0]  LS_PTR_SEL,
   input  logic [31:0] LS_PTR,
   output logic [2:0]  LS_STORE_SEL,
   input  logic [31:0] LS_STORE,

   output logic        LS_PTR_UPD_VLD,
   output logic [2:0]  LS_PTR_UPD_SEL,
   output logic [31:0] LS_PTR_UPD,

   tawas_ls_wait_if.master bus,

   output logic        LSD_LOAD_VLD,
   output logic [2:0]  LSD_LOAD_SEL,
   output logic [31:0] LSD_LOAD,

   output logic        LS_BUSY,
   output logic        LS_ERR,
   output logic        DBG_STATE
);

   // Handshakes: an op transfers on the rising edge where LS_OP_VLD && LS_OP_RDY;
   // a bus request transfers where DREQ && DACK, DREQ and its payload holding until then.
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} ls_state_t;

   typedef struct packed {
      logic [2:0] dest;
      logic [1:0] size;   // 0 byte, 1 half, 2 word
      logic [1:0] lane;
      logic       sext;
   } pend_t;

   localparam logic [PEND_AW:0] DEPTH_C = PEND_DEPTH[PEND_AW:0];

   ls_state_t state_q, state_d;

   logic [31:0] req_addr, req_dout;
   logic [3:0]  req_mask;
   logic        req_wr;
   pend_t       req_ent;

   pend_t             pend_mem [PEND_DEPTH];
   logic [PEND_AW-1:0] wr_ptr, rd_ptr;
   logic [PEND_AW:0]   fifo_cnt, occ;

   logic        accept, push, pop, dreq, req_load;
   logic        op_word, op_half, op_upd, op_store;
   logic [4:0]  imm5;
   logic [5:0]  imm6;
   logic [31:0] off_z, adj, acc_addr, ptr_new, dout_in;
   logic [3:0]  mask_in;
   pend_t       ent_in, head;
   logic [4:0]  shamt;
   logic [31:0] shifted, load_fmt;
   logic        sx;

   assign LS_PTR_SEL   = LS_OP[5:3];
   assign LS_STORE_SEL = LS_OP[2:0];
   assign op_word  = LS_OP[12];
   assign op_half  = LS_OP[11] & ~LS_OP[12];
   assign op_upd   = LS_OP[13];
   assign op_store = LS_OP[14];
   assign imm5     = LS_OP[10:6];
   assign imm6     = LS_OP[11:6];

   assign dreq     = (state_q == ST_REQ);
   assign req_load = dreq & ~req_wr;
   assign occ      = fifo_cnt + {{PEND_AW{1'b0}}, req_load};
   // Conservative: a pop in this same cycle does not free a slot until next cycle.
   assign LS_OP_RDY = (~dreq | bus.DACK) & (occ < DEPTH_C);
   assign accept    = LS_OP_VLD & LS_OP_RDY;
   assign push      = req_load & bus.DACK;
   assign pop       = bus.DRD_VLD & (fifo_cnt != '0);

   // Address generation: pre-decrement for negative update offsets, post-increment otherwise.
   always_comb begin
      off_z = '0;
      adj   = '0;
      if (op_word) begin
         off_z = {24'd0, imm6, 2'b00};
         adj   = {{24{imm6[5]}}, imm6, 2'b00};
      end else if (op_half) begin
         off_z = {26'd0, imm5, 1'b0};
         adj   = {{26{imm5[4]}}, imm5, 1'b0};
      end else begin
         off_z = {27'd0, imm5};
         adj   = {{27{imm5[4]}}, imm5};
      end
      ptr_new  = LS_PTR + adj;
      acc_addr = LS_PTR + off_z;
      if (op_upd) acc_addr = adj[31] ? ptr_new : LS_PTR;

      mask_in = 4'b0001 << acc_addr[1:0];
      dout_in = {4{LS_STORE[7:0]}};
      if (op_word) begin
         mask_in = 4'b1111;
         dout_in = LS_STORE;
      end else if (op_half) begin
         mask_in = acc_addr[1] ? 4'b1100 : 4'b0011;
         dout_in = {2{LS_STORE[15:0]}};
      end
      if (!op_store) dout_in = '0;

      ent_in.dest = LS_OP[2:0];
      ent_in.size = op_word ? 2'd2 : (op_half ? 2'd1 : 2'd0);
      ent_in.lane = acc_addr[1:0];
      ent_in.sext = LS_OP[15];
   end

   always_comb begin
      state_d = state_q;
      if (accept)
         state_d = ST_REQ;
      else if (dreq && bus.DACK)
         state_d = ST_IDLE;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         req_addr <= '0;
         req_dout <= '0;
         req_mask <= '0;
         req_wr   <= 1'b0;
         req_ent  <= '0;
      end else if (accept) begin
         req_addr <= {acc_addr[31:2], 2'b00};
         req_dout <= dout_in;
         req_mask <= mask_in;
         req_wr   <= op_store;
         req_ent  <= ent_in;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         LS_PTR_UPD_VLD <= 1'b0;
         LS_PTR_UPD_SEL <= '0;
         LS_PTR_UPD     <= '0;
      end else begin
         LS_PTR_UPD_VLD <= accept & op_upd;
         LS_PTR_UPD_SEL <= (accept && op_upd) ? LS_OP[5:3] : 3'd0;
         LS_PTR_UPD     <= (accept && op_upd) ? ptr_new : 32'd0;
      end
   end

   assign bus.DREQ  = dreq;
   assign bus.DADDR = req_addr;
   assign bus.DWR   = req_wr;
   assign bus.DMASK = req_mask;
   assign bus.DOUT  = req_dout;

   always_ff @(posedge CLK) begin
      if (push) pend_mem[wr_ptr] <= req_ent;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Move the addressed lane down to bit 0 and extend according to access size.
   always_comb begin
      head  = pend_mem[rd_ptr];
      shamt = {head.lane, 3'b000};
      if (head.size == 2'd2)      shamt = 5'd0;
      else if (head.size == 2'd1) shamt = {head.lane[1], 4'b0000};
      shifted = bus.DIN >> shamt;
      sx      = head.sext & SIGN_EXT_EN;
      if (head.size == 2'd2)
         load_fmt = bus.DIN;
      else if (head.size == 2'd1)
         load_fmt = {{16{sx & shifted[15]}}, shifted[15:0]};
      else
         load_fmt = {{24{sx & shifted[7]}}, shifted[7:0]};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         LSD_LOAD_VLD <= 1'b0;
         LSD_LOAD_SEL <= '0;
         LSD_LOAD     <= '0;
         LS_ERR       <= 1'b0;
      end else begin
         LSD_LOAD_VLD <= pop;
         LSD_LOAD_SEL <= pop ? head.dest : 3'd0;
         LSD_LOAD     <= pop ? load_fmt : 32'd0;
         LS_ERR       <= bus.DRD_VLD & (fifo_cnt == '0);
      end
   end

   assign LS_BUSY   = dreq | (fifo_cnt != '0);
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_tawas_ls_wait.sv
// Directed bench for tawas_ls_wait: single-op vector table plus wait-state,
// FIFO-full, empty-response and mid-operation reset sequences.
module tb_tawas_ls_wait;

   logic        CLK = 1'b0;
   logic        RST;
   always #5 CLK = ~CLK;

   logic        ls_op_vld;
   logic [15:0] ls_op;
   logic [31:0] ls_ptr, ls_store;
   logic        rdy, upd_vld, load_vld, busy, err, dbg;
   logic [2:0]  ptr_sel, store_sel, upd_sel, load_sel;
   logic [31:0] upd, load;
   logic        rdy_b, upd_vld_b, load_vld_b, busy_b, err_b, dbg_b;
   logic [2:0]  ptr_sel_b, store_sel_b, upd_sel_b, load_sel_b;
   logic [31:0] upd_b, load_b;

   tawas_ls_wait_if bus_a ();
   tawas_ls_wait_if bus_b ();
   assign bus_b.DACK    = bus_a.DACK;
   assign bus_b.DRD_VLD = bus_a.DRD_VLD;
   assign bus_b.DIN     = bus_a.DIN;

   tawas_ls_wait #(.PEND_DEPTH(4), .PEND_AW(2), .SIGN_EXT_EN(1'b1)) dut (
      .CLK(CLK), .RST(RST),
      .LS_OP_VLD(ls_op_vld), .LS_OP_RDY(rdy), .LS_OP(ls_op),
      .LS_PTR_SEL(ptr_sel), .LS_PTR(ls_ptr), .LS_STORE_SEL(store_sel), .LS_STORE(ls_store),
      .LS_PTR_UPD_VLD(upd_vld), .LS_PTR_UPD_SEL(upd_sel), .LS_PTR_UPD(upd),
      .bus(bus_a.master),
      .LSD_LOAD_VLD(load_vld), .LSD_LOAD_SEL(load_sel), .LSD_LOAD(load),
      .LS_BUSY(busy), .LS_ERR(err), .DBG_STATE(dbg)
   );

   tawas_ls_wait #(.PEND_DEPTH(4), .PEND_AW(2), .SIGN_EXT_EN(1'b0)) dut_nx (
      .CLK(CLK), .RST(RST),
      .LS_OP_VLD(ls_op_vld), .LS_OP_RDY(rdy_b), .LS_OP(ls_op),
      .LS_PTR_SEL(ptr_sel_b), .LS_PTR(ls_ptr), .LS_STORE_SEL(store_sel_b), .LS_STORE(ls_store),
      .LS_PTR_UPD_VLD(upd_vld_b), .LS_PTR_UPD_SEL(upd_sel_b), .LS_PTR_UPD(upd_b),
      .bus(bus_b.master),
      .LSD_LOAD_VLD(load_vld_b), .LSD_LOAD_SEL(load_sel_b), .LSD_LOAD(load_b),
      .LS_BUSY(busy_b), .LS_ERR(err_b), .DBG_STATE(dbg_b)
   );

   typedef struct {
      logic [15:0] op;
      logic [31:0] ptr;
      logic [31:0] st;
      logic [31:0] din;
      logic [31:0] e_addr;
      logic [3:0]  e_mask;
      logic        e_wr;
      logic [31:0] e_dout;
      logic        e_upd_vld;
      logic [2:0]  e_upd_sel;
      logic [31:0] e_upd;
      logic [2:0]  e_sel;
      logic [31:0] e_load;
      logic [31:0] e_load_nx;
   } vec_t;

   vec_t vecs [8];

   int checks = 0;
   int errors = 0;
   logic [34:0] exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic check_load(input string name);
      logic [34:0] e;
      chk({name, "_vld"}, 64'(load_vld), 64'd1);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s act=response exp=no_entry", name);
      end else begin
         e = exp_q.pop_front();
         chk(name, 64'({load_sel, load}), 64'(e));
      end
   endtask

   // One read beat at the next rising edge; the load writeback is checked one cycle later.
   task automatic resp(input logic [31:0] d, input string name);
      bus_a.DRD_VLD = 1'b1;
      bus_a.DIN     = d;
      @(negedge CLK);
      bus_a.DRD_VLD = 1'b0;
      #1;
      check_load(name);
   endtask

   initial begin
      vecs[0] = '{16'h10CA, 32'h100,  32'h0,        32'hDEADBEEF, 32'h10C,      4'hF, 1'b0, 32'h0,        1'b0, 3'd0, 32'h0,        3'd2, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1] = '{16'h801D, 32'h203,  32'h0,        32'h80000000, 32'h200,      4'h8, 1'b0, 32'h0,        1'b0, 3'd0, 32'h0,        3'd5, 32'hFFFFFF80, 32'h00000080};
      vecs[2] = '{16'h6FE6, 32'h400,  32'h1234ABCD, 32'h0,        32'h3FC,      4'hC, 1'b1, 32'hABCDABCD, 1'b1, 3'd4, 32'h3FE,      3'd0, 32'h0,        32'h0};
      vecs[3] = '{16'hA847, 32'h502,  32'h0,        32'h80011234, 32'h500,      4'hC, 1'b0, 32'h0,        1'b1, 3'd0, 32'h504,      3'd7, 32'hFFFF8001, 32'h00008001};
      vecs[4] = '{16'h4151, 32'h1000, 32'hFFFFFF5A, 32'h0,        32'h1004,     4'h2, 1'b1, 32'h5A5A5A5A, 1'b0, 3'd0, 32'h0,        3'd0, 32'h0,        32'h0};
      vecs[5] = '{16'h7FE8, 32'h0,    32'hCAFEF00D, 32'h0,        32'hFFFFFFFC, 4'hF, 1'b1, 32'hCAFEF00D, 1'b1, 3'd5, 32'hFFFFFFFC, 3'd0, 32'h0,        32'h0};
      vecs[6] = '{16'h000B, 32'h20,   32'h0,        32'h123456F0, 32'h20,       4'h1, 1'b0, 32'h0,        1'b0, 3'd0, 32'h0,        3'd3, 32'h000000F0, 32'h000000F0};
      vecs[7] = '{16'h0881, 32'h10,   32'h0,        32'hABCD9876, 32'h14,       4'h3, 1'b0, 32'h0,        1'b0, 3'd0, 32'h0,        3'd1, 32'h00009876, 32'h00009876};

      // Clock/reset
      RST = 1'b1;
      ls_op_vld = 1'b0; ls_op = '0; ls_ptr = '0; ls_store = '0;
      bus_a.DACK = 1'b0; bus_a.DRD_VLD = 1'b0; bus_a.DIN = '0;
      repeat (2) @(negedge CLK);
      #1;
      chk("rst_rdy", 64'(rdy), 64'd1);
      chk("rst_dreq", 64'(bus_a.DREQ), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_load_vld", 64'(load_vld), 64'd0);
      chk("rst_upd_vld", 64'(upd_vld), 64'd0);
      chk("rst_state", 64'(dbg), 64'd0);
      @(negedge CLK);
      RST = 1'b0;

      // Single-op vectors: accept, DACK with DREQ, read data two cycles later.
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         ls_op_vld = 1'b1;
         ls_op     = vecs[i].op;
         ls_ptr    = vecs[i].ptr;
         ls_store  = vecs[i].st;
         #1;
         chk($sformatf("v%0d_rdy", i), 64'(rdy), 64'd1);
         @(negedge CLK);
         ls_op_vld = 1'b0;
         #1;
         chk($sformatf("v%0d_dreq", i), 64'(bus_a.DREQ), 64'd1);
         chk($sformatf("v%0d_daddr", i), 64'(bus_a.DADDR), 64'(vecs[i].e_addr));
         chk($sformatf("v%0d_dmask", i), 64'(bus_a.DMASK), 64'(vecs[i].e_mask));
         chk($sformatf("v%0d_dwr", i), 64'(bus_a.DWR), 64'(vecs[i].e_wr));
         chk($sformatf("v%0d_dout", i), 64'(bus_a.DOUT), 64'(vecs[i].e_dout));
         chk($sformatf("v%0d_upd", i), 64'({upd_vld, upd_sel, upd}),
             64'({vecs[i].e_upd_vld, vecs[i].e_upd_sel, vecs[i].e_upd}));
         bus_a.DACK = 1'b1;
         @(negedge CLK);
         bus_a.DACK = 1'b0;
         #1;
         chk($sformatf("v%0d_dreq_drop", i), 64'(bus_a.DREQ), 64'd0);
         chk($sformatf("v%0d_upd_pulse", i), 64'(upd_vld), 64'd0);
         @(negedge CLK);
         if (!vecs[i].e_wr) begin
            bus_a.DRD_VLD = 1'b1;
            bus_a.DIN     = vecs[i].din;
            @(negedge CLK);
            bus_a.DRD_VLD = 1'b0;
            #1;
            chk($sformatf("v%0d_load_vld", i), 64'(load_vld), 64'd1);
            chk($sformatf("v%0d_load_sel", i), 64'(load_sel), 64'(vecs[i].e_sel));
            chk($sformatf("v%0d_load", i), 64'(load), 64'(vecs[i].e_load));
            chk($sformatf("v%0d_load_nx", i), 64'(load_b), 64'(vecs[i].e_load_nx));
            @(negedge CLK);
            #1;
            chk($sformatf("v%0d_load_pulse", i), 64'(load_vld), 64'd0);
         end
         chk($sformatf("v%0d_idle", i), 64'(busy), 64'd0);
      end

      // Wait states: DACK low for 5 cycles with a second op waiting.
      @(negedge CLK);
      ls_op_vld = 1'b1; ls_op = 16'h1049; ls_ptr = 32'h800;
      exp_q.push_back({3'd1, 32'h11111111});
      @(negedge CLK);
      ls_op = 16'h108A; ls_ptr = 32'h900;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("ws%0d_dreq", c), 64'(bus_a.DREQ), 64'd1);
         chk($sformatf("ws%0d_daddr", c), 64'(bus_a.DADDR), 64'h804);
         chk($sformatf("ws%0d_rdy", c), 64'(rdy), 64'd0);
         @(negedge CLK);
      end
      bus_a.DACK = 1'b1;
      #1;
      chk("ws_rdy_dack", 64'(rdy), 64'd1);
      exp_q.push_back({3'd2, 32'h22222222});
      @(negedge CLK);
      ls_op_vld = 1'b0;
      #1;
      chk("ws_next_dreq", 64'(bus_a.DREQ), 64'd1);
      chk("ws_next_daddr", 64'(bus_a.DADDR), 64'h908);
      @(negedge CLK);
      bus_a.DACK = 1'b0;
      #1;
      chk("ws_busy", 64'(busy), 64'd1);
      resp(32'h11111111, "ws_resp0");
      resp(32'h22222222, "ws_resp1");

      // Fill the pending FIFO with four word loads and no responses.
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         ls_op_vld = 1'b1;
         ls_op = 16'h1000 | 16'(i + 4);
         ls_ptr = 32'h1000 + 32'(i * 16);
         bus_a.DACK = 1'b1;
         #1;
         chk($sformatf("full_issue%0d_rdy", i), 64'(rdy), 64'd1);
         exp_q.push_back({3'(i + 4), 32'hA0000000 + 32'(i)});
      end
      @(negedge CLK);
      ls_op_vld = 1'b0;
      #1;
      chk("full_occ4_rdy", 64'(rdy), 64'd0);
      @(negedge CLK);
      bus_a.DACK = 1'b0;
      #1;
      chk("full_fifo4_rdy", 64'(rdy), 64'd0);
      bus_a.DRD_VLD = 1'b1;
      bus_a.DIN = 32'hA0000000;
      #1;
      chk("full_pop_same_cycle_rdy", 64'(rdy), 64'd0);
      @(negedge CLK);
      bus_a.DRD_VLD = 1'b0;
      #1;
      chk("full_rdy_restored", 64'(rdy), 64'd1);
      check_load("full_resp0");
      for (int i = 1; i < 4; i++) begin
         @(negedge CLK);
         resp(32'hA0000000 + 32'(i), $sformatf("full_resp%0d", i));
      end

      // Read beat with nothing pending.
      @(negedge CLK);
      bus_a.DRD_VLD = 1'b1; bus_a.DIN = 32'h55555555;
      @(negedge CLK);
      bus_a.DRD_VLD = 1'b0;
      #1;
      chk("empty_err", 64'(err), 64'd1);
      chk("empty_no_load", 64'(load_vld), 64'd0);
      @(negedge CLK);
      #1;
      chk("empty_err_pulse", 64'(err), 64'd0);

      // Asynchronous reset with two loads pending, then two orphan beats.
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         ls_op_vld = 1'b1; ls_op = 16'h1001; ls_ptr = 32'h40; bus_a.DACK = 1'b1;
      end
      @(negedge CLK);
      ls_op_vld = 1'b0;
      @(negedge CLK);
      bus_a.DACK = 1'b0;
      #1;
      chk("rst2_busy_before", 64'(busy), 64'd1);
      #2;
      RST = 1'b1;
      #1;
      chk("rst2_busy_after", 64'(busy), 64'd0);
      chk("rst2_dreq", 64'(bus_a.DREQ), 64'd0);
      @(negedge CLK);
      RST = 1'b0;
      bus_a.DRD_VLD = 1'b1; bus_a.DIN = 32'h12345678;
      @(negedge CLK);
      #1;
      chk("rst2_err0", 64'(err), 64'd1);
      chk("rst2_no_load0", 64'(load_vld), 64'd0);
      @(negedge CLK);
      bus_a.DRD_VLD = 1'b0;
      #1;
      chk("rst2_err1", 64'(err), 64'd1);
      chk("rst2_no_load1", 64'(load_vld), 64'd0);
      @(negedge CLK);
      #1;
      chk("rst2_err_end", 64'(err), 64'd0);
      chk("final_q_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
